mux16_tdm: RTL and testbench
============================

# mux16_tdm

Time-division multiplexing transmitter that is the sending end of the 16-channel demultiplexer. It latches a 16-bit word and emits one bit per clock cycle on `Dado`, with the matching channel index on `Escolha`. A receiving demux16 steered by `Escolha` then routes each bit back to its original lane. The block sits between a parallel producer and a single serial link, and supports back-to-back words and stalls.

## Interface
Parameters:
- `LSB_PRIMEIRO`, default 1: sets the transmit order.
  - 1: channel 0 is sent first, and `Escolha` counts 0→15.
  - 0: channel 15 is sent first, and `Escolha` counts 15→0.

Ports:
- `Clock` input 1: the single clock. All state changes on its rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Entrada` input 16: parallel word. It is sampled only on an accepted load.
- `Carregar` input 1: load request. It is accepted when `Carregar & Pronto` in a cycle.
- `Pausa` input 1: stall. While high, the current bit is held and not advanced.
- `Dado` output 1: serial bit, equal to the latched word bit at `Escolha`.
- `Escolha` output 4: index of the channel currently being presented.
- `Valido` output 1: `Dado`/`Escolha` form a bit to be consumed this cycle.
- `Fim` output 1: the current bit is the last bit of the word.
- `Pronto` output 1: a load is accepted this cycle if `Carregar` is high.

## Operation
- Internal registers:
  - `palavra` [15:0], the latched word.
  - `indice` [3:0], which drives `Escolha`.
  - `ativo`, 1 bit.
- States:
  - OCIOSO: `ativo`=0.
  - TRANSMITINDO: `ativo`=1.
- Constants: `primeiro` = 0 and `ultimo` = 15 when `LSB_PRIMEIRO`=1. They are swapped when `LSB_PRIMEIRO`=0.
- Combinational outputs:
  - `Dado` = `palavra[indice]`.
  - `Escolha` = `indice`.
  - `Valido` = `ativo & ~Pausa`.
  - `Fim` = `ativo & (indice == ultimo)`.
  - `Pronto` = `~ativo | (Fim & ~Pausa)`.
- Accepted load (`Carregar & Pronto`): `palavra` ← `Entrada`, `indice` ← `primeiro`, `ativo` ← 1.
- In TRANSMITINDO with `Pausa`=0 and `indice` ≠ `ultimo`: `indice` steps by ±1 according to `LSB_PRIMEIRO`.
- In TRANSMITINDO with `Pausa`=0 and `indice` = `ultimo`:
  - If `Carregar`=1, this is a back-to-back reload, as in the load rule above.
  - Otherwise `ativo` ← 0, and the block returns to OCIOSO.
- Stalls:
  - `Pausa`=1 in TRANSMITINDO freezes `palavra`, `indice` and `ativo`.
  - `Carregar` is ignored while stalled, because `Pronto`=0.
  - `Pausa` in OCIOSO has no effect, and loads are still accepted.
- `Carregar` while `Pronto`=0 is ignored entirely. `Entrada` is not sampled and the word in flight is not disturbed.
- Register holds:
  - In OCIOSO, `palavra` and `indice` hold their last values.
  - `Dado`/`Escolha` may be nonzero there but are qualified by `Valido`=0.

## Timing
- Reset (`Reset`=1 at a clock edge) forces:
  - `ativo`=0 and `palavra`=16'h0000.
  - `indice`=`primeiro`.
- Outputs after reset: `Valido`=0, `Fim`=0, `Pronto`=1, `Dado`=0, `Escolha`=`primeiro`.
- `Reset` overrides `Carregar` and `Pausa` in the same cycle.
- Reset mid-word aborts the word. No further `Valido` bits are produced from it.
- Latency: load accepted at edge N → first bit has `Valido`=1 in the cycle following edge N.
- Without stalls, a word occupies exactly 16 consecutive `Valido` cycles.
- Back-to-back throughput is one bit per clock with no idle cycle between words: the bit after `ultimo` is `primeiro` of the new word.
- Each stall cycle extends the word by one cycle and produces a `Valido`=0 gap. The same bit reappears when `Pausa` falls.
- `Pronto` and `Valido` depend combinationally on `Pausa`. This is the only input-to-output combinational path, and `Carregar` must not feed back into `Pronto`.

## Test plan
- **Reset values:** hold `Reset` 2 cycles with `Carregar`=1 → `Valido`=0, `Fim`=0, `Pronto`=1, `Escolha`=0, `Dado`=0. No load is taken.
- **Single word:** load 16'hA5C3 with `LSB_PRIMEIRO`=1 → 16 `Valido` cycles.
  - `Escolha` runs 0..15 and `Dado` sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `Fim` is high only at `Escolha`=15.
  - `Valido`=0 on the next cycle.
  - A demux16 plus a 16-bit register written on `Valido` reconstructs 16'hA5C3.
- **Back-to-back:** load 16'hFFFF, then hold `Carregar`=1 with `Entrada`=16'h0001 → 32 contiguous `Valido` cycles.
  - Second word bit 0 is 1 at cycle 17; bits 1–15 are 0.
  - `Pronto` is high only at cycle 16 and after the end.
- **Stall:** assert `Pausa` for 3 cycles at `Escolha`=7 → `Valido`=0 for those 3 cycles. `Escolha` stays 7 and `Dado` stays `word[7]`. The word completes after 19 cycles total.
  - `Pausa` at `Escolha`=15 with `Carregar`=1 → no reload until `Pausa` falls.
- **Ignored load / reset mid-word:**
  - `Carregar` with a different `Entrada` at `Escolha`=4 → the word is unchanged.
  - `Reset` at `Escolha`=9 → `Valido`=0 on the next cycle, `Pronto`=1.
  - A subsequent load starts cleanly at `Escolha`=0.
- **Reverse order:** `LSB_PRIMEIRO`=0, load 16'h8001 → `Escolha` runs 15..0. `Dado`=1 at the first and last bit and 0 elsewhere; `Fim` is high at `Escolha`=0.

Source files
------------

// File: rtl/mux16_tdm.sv
// mux16_tdm: 16-channel time-division multiplexing transmitter.
// Latches a 16-bit word and sends it one bit per clock. Escolha carries the
// channel index of the bit currently on Dado, so a demux16 at the far end can
// steer each bit back to its lane. Back-to-back words and stalls are supported.
//
// Parameters:
//   LSB_PRIMEIRO : 1 -> channel 0 first (Escolha counts 0..15)
//                  0 -> channel 15 first (Escolha counts 15..0)
// Ports:
//   Clock    : rising-edge clock
//   Reset    : synchronous, active-high reset
//   Entrada  : parallel word, sampled only on an accepted load
//   Carregar : load request, accepted when Carregar & Pronto
//   Pausa    : stall, holds the current bit while high
//   Dado     : serial bit, palavra[Escolha]
//   Escolha  : channel index of the bit being presented
//   Valido   : Dado/Escolha are to be consumed this cycle
//   Fim      : the current bit is the last of the word
//   Pronto   : a load would be accepted this cycle
module mux16_tdm #(
   parameter int unsigned LSB_PRIMEIRO = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] Entrada,
   input  logic        Carregar,
   input  logic        Pausa,
   output logic        Dado,
   output logic [3:0]  Escolha,
   output logic        Valido,
   output logic        Fim,
   output logic        Pronto
);

   typedef enum logic {
      OCIOSO       = 1'b0,
      TRANSMITINDO = 1'b1
   } estado_t;

   localparam logic [3:0] PRIMEIRO = (LSB_PRIMEIRO != 0) ? 4'd0  : 4'd15;
   localparam logic [3:0] ULTIMO   = (LSB_PRIMEIRO != 0) ? 4'd15 : 4'd0;

   estado_t     estado_q, estado_d;
   logic [15:0] palavra_q, palavra_d;
   logic [3:0]  indice_q, indice_d;

   logic ativo;
   logic fim;
   logic pronto;
   logic carga;

   always_comb begin
      ativo  = (estado_q == TRANSMITINDO);
      fim    = ativo && (indice_q == ULTIMO);
      // Pronto must depend only on state and Pausa, never on Carregar.
      pronto = !ativo || (fim && !Pausa);
      carga  = Carregar && pronto;

      estado_d  = estado_q;
      palavra_d = palavra_q;
      indice_d  = indice_q;

      // A load at the last bit is the back-to-back reload; it takes
      // priority over the return to OCIOSO.
      if (carga) begin
         palavra_d = Entrada;
         indice_d  = PRIMEIRO;
         estado_d  = TRANSMITINDO;
      end else if (ativo && !Pausa) begin
         if (fim) begin
            estado_d = OCIOSO;
         end else if (LSB_PRIMEIRO != 0) begin
            indice_d = indice_q + 4'd1;
         end else begin
            indice_d = indice_q - 4'd1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q  <= OCIOSO;
         palavra_q <= '0;
         indice_q  <= PRIMEIRO;
      end else begin
         estado_q  <= estado_d;
         palavra_q <= palavra_d;
         indice_q  <= indice_d;
      end
   end

   assign Dado    = palavra_q[indice_q];
   assign Escolha = indice_q;
   assign Valido  = ativo && !Pausa;
   assign Fim     = fim;
   assign Pronto  = pronto;

endmodule

// File: tb/tb_mux16_tdm.sv
// Bench for mux16_tdm: drives one forward (LSB_PRIMEIRO=1) and one reverse
// (LSB_PRIMEIRO=0) instance from the same inputs and compares both against a
// word/bit-count reference model, plus a demux16-style receiver per instance.
module tb_mux16_tdm;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] Entrada;
   logic        Carregar;
   logic        Pausa;

   logic        dado_f, valido_f, fim_f, pronto_f;
   logic [3:0]  esc_f;
   logic        dado_r, valido_r, fim_r, pronto_r;
   logic [3:0]  esc_r;

   always #5 Clock = ~Clock;

   mux16_tdm #(.LSB_PRIMEIRO(1)) dut_f (
      .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carregar(Carregar),
      .Pausa(Pausa), .Dado(dado_f), .Escolha(esc_f), .Valido(valido_f),
      .Fim(fim_f), .Pronto(pronto_f)
   );

   mux16_tdm #(.LSB_PRIMEIRO(0)) dut_r (
      .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carregar(Carregar),
      .Pausa(Pausa), .Dado(dado_r), .Escolha(esc_r), .Valido(valido_r),
      .Fim(fim_r), .Pronto(pronto_r)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model: the word in flight, how many bits of it have been
   // delivered so far (m_k), and whether a word is in flight.
   logic [15:0] m_w = '0;
   int          m_k = 0;
   bit          m_act = 1'b0;
   bit          m_known = 1'b0;

   // Receiver side: register written at lane Escolha whenever Valido.
   logic [15:0] rec_f = '0;
   logic [15:0] rec_r = '0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit rst, input bit ld, input logic [15:0] ent, input bit pz);
      logic e_val;
      logic e_fim;
      logic e_pr;
      Reset    = rst;
      Carregar = ld;
      Entrada  = ent;
      Pausa    = pz;
      e_val = m_act && !pz;
      e_fim = m_act && (m_k == 15);
      e_pr  = !m_act || (e_fim && !pz);
      #2;
      if (m_known) begin
         chk("valido_f", {15'd0, valido_f}, {15'd0, e_val});
         chk("valido_r", {15'd0, valido_r}, {15'd0, e_val});
         chk("fim_f",    {15'd0, fim_f},    {15'd0, e_fim});
         chk("fim_r",    {15'd0, fim_r},    {15'd0, e_fim});
         chk("pronto_f", {15'd0, pronto_f}, {15'd0, e_pr});
         chk("pronto_r", {15'd0, pronto_r}, {15'd0, e_pr});
         chk("escolha_f", {12'd0, esc_f}, {12'd0, 4'(m_k)});
         chk("escolha_r", {12'd0, esc_r}, {12'd0, 4'(15 - m_k)});
         chk("dado_f", {15'd0, dado_f}, {15'd0, m_w[m_k]});
         chk("dado_r", {15'd0, dado_r}, {15'd0, m_w[15 - m_k]});
         if (valido_f === 1'b1) rec_f[esc_f] = dado_f;
         if (valido_r === 1'b1) rec_r[esc_r] = dado_r;
         if (e_val && e_fim) begin
            chk("rx_word_f", rec_f, m_w);
            chk("rx_word_r", rec_r, m_w);
         end
      end
      @(posedge Clock);
      if (rst) begin
         m_act = 1'b0;
         m_w   = '0;
         m_k   = 0;
      end else if (ld && e_pr) begin
         m_act = 1'b1;
         m_w   = ent;
         m_k   = 0;
      end else if (m_act && !pz) begin
         if (m_k == 15) m_act = 1'b0;
         else m_k = m_k + 1;
      end
      m_known = 1'b1;
      @(negedge Clock);
   endtask

   initial begin
      // Reset for two cycles with a load request pending: no load taken.
      tick(1'b1, 1'b1, 16'hBEEF, 1'b0);
      tick(1'b1, 1'b1, 16'hBEEF, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b0);

      // Single word, then one idle cycle.
      tick(1'b0, 1'b1, 16'hA5C3, 1'b0);
      for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("a5c3_rx_f", rec_f, 16'hA5C3);
      chk("a5c3_rx_r", rec_r, 16'hA5C3);

      // Back-to-back: FFFF then 0001 with Carregar held through the first word.
      tick(1'b0, 1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 16'h0001, 1'b0);
      for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);

      // Stall at bit 7 for 3 cycles, then stall at the last bit with a reload
      // pending; the reload happens only once Pausa falls.
      tick(1'b0, 1'b1, 16'h3C96, 1'b0);
      for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'h1111, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 16'h5A5A, 1'b1);
      tick(1'b0, 1'b1, 16'h5A5A, 1'b0);
      for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);

      // Ignored load mid-word, then reset at bit 9 and a clean restart.
      tick(1'b0, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(1'b0, 1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(1'b1, 1'b0, 16'h0000, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1'b0, 1'b1, 16'h8001, 1'b0);
      for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("8001_rx_f", rec_f, 16'h8001);
      chk("8001_rx_r", rec_r, 16'h8001);

      // Randomized traffic: loads, stalls and occasional resets.
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
              16'($urandom), $urandom_range(0, 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
